// File: rtl/maze_step_unit_if.sv
// Direction-counter and wall-memory signals of the maze step unit.
// master: step unit side; slave: counter/memory side.
interface maze_step_unit_if #(
  parameter int unsigned COORD_W = 4
);
  logic [1:0]           dir;
  logic                 dir_wrap;
  logic                 cnt_en;
  logic                 cnt_ld;
  logic [1:0]           cnt_par;
  logic                 cnt_clr;
  logic                 mem_rd;
  logic [2*COORD_W-1:0] mem_addr;
  logic                 mem_ack;
  logic                 mem_wall;

  modport master (
    input  dir, dir_wrap, mem_ack, mem_wall,
    output cnt_en, cnt_ld, cnt_par, cnt_clr, mem_rd, mem_addr
  );

  modport slave (
    output dir, dir_wrap, mem_ack, mem_wall,
    input  cnt_en, cnt_ld, cnt_par, cnt_clr, mem_rd, mem_addr
  );
endinterface

// File: rtl/maze_step_unit.sv
// Rat position and single-step move attempt for the Rat & Maze datapath.
// Optional MAZE_LAST_DIR_EN: after a move, reload the direction counter one step counter-clockwise.
module maze_step_unit #(
  parameter int unsigned COORD_W = 4,
  parameter int unsigned GOAL_X  = 15,
  parameter int unsigned GOAL_Y  = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  maze_step_unit_if.master   bus,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic               busy,
  output logic               moved,
  output logic               dead_end,
  output logic               goal
);

  localparam logic [COORD_W-1:0] Max   = '1;
  localparam logic [COORD_W-1:0] One   = COORD_W'(1);
  localparam logic [COORD_W-1:0] GoalX = COORD_W'(GOAL_X);
  localparam logic [COORD_W-1:0] GoalY = COORD_W'(GOAL_Y);

  typedef enum logic [2:0] {
    StIdle, StCheck, StReq, StMove, StNext, StSettle, StDone
  } state_e;

  state_e state_q, state_d;
  logic [COORD_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [COORD_W-1:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
  logic [COORD_W-1:0] cand_x, cand_y;
  logic blocked;
  logic busy_q, moved_q, dead_q, goal_q, cnt_en_q, cnt_clr_q, mem_rd_q;
  logic busy_d, moved_d, dead_d, goal_d, cnt_en_d, cnt_clr_d, mem_rd_d;

  // Candidate cell and boundary check for the direction currently presented.
  always_comb begin
    cand_x  = pos_x_q;
    cand_y  = pos_y_q;
    blocked = 1'b0;
    unique case (bus.dir)
      2'd0: begin blocked = (pos_y_q == '0);  cand_y = pos_y_q - One; end
      2'd1: begin blocked = (pos_x_q == Max); cand_x = pos_x_q + One; end
      2'd2: begin blocked = (pos_y_q == Max); cand_y = pos_y_q + One; end
      default: begin blocked = (pos_x_q == '0); cand_x = pos_x_q - One; end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    cand_x_d = cand_x_q;
    cand_y_d = cand_y_q;
    dead_d   = 1'b0;
    unique case (state_q)
      StIdle:  if (start) state_d = StCheck;
      StCheck: begin
        cand_x_d = cand_x;
        cand_y_d = cand_y;
        state_d  = blocked ? StNext : StReq;
      end
      StReq: begin
        if (bus.mem_ack) begin
          if (bus.mem_wall) begin
            state_d = StNext;
          end else begin
            // Position updates on entry so it is visible alongside the moved pulse.
            state_d = StMove;
            pos_x_d = cand_x_q;
            pos_y_d = cand_y_q;
          end
        end
      end
      StMove:   state_d = (cand_x_q == GoalX && cand_y_q == GoalY) ? StDone : StIdle;
      StNext:   state_d = StSettle;
      StSettle: begin
        state_d = bus.dir_wrap ? StIdle : StCheck;
        dead_d  = bus.dir_wrap;
      end
      StDone:   state_d = StDone;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next-state decode.
  always_comb begin
    busy_d   = (state_d != StIdle);
    moved_d  = (state_d == StMove);
    goal_d   = (state_d == StDone);
    cnt_en_d = (state_d == StNext);
    mem_rd_d = (state_d == StReq);
`ifdef MAZE_LAST_DIR_EN
    cnt_clr_d = dead_d;
`else
    cnt_clr_d = dead_d | moved_d;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      cand_x_q  <= '0;
      cand_y_q  <= '0;
      busy_q    <= 1'b0;
      moved_q   <= 1'b0;
      dead_q    <= 1'b0;
      goal_q    <= 1'b0;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      mem_rd_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      cand_x_q  <= cand_x_d;
      cand_y_q  <= cand_y_d;
      busy_q    <= busy_d;
      moved_q   <= moved_d;
      dead_q    <= dead_d;
      goal_q    <= goal_d;
      cnt_en_q  <= cnt_en_d;
      cnt_clr_q <= cnt_clr_d;
      mem_rd_q  <= mem_rd_d;
    end
  end

`ifdef MAZE_LAST_DIR_EN
  logic [1:0] dir_q, dir_d, cnt_par_q;
  logic       cnt_ld_q;

  always_comb begin
    dir_d = dir_q;
    if (state_q == StCheck) dir_d = bus.dir;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_q     <= 2'd0;
      cnt_ld_q  <= 1'b0;
      cnt_par_q <= 2'd0;
    end else begin
      dir_q     <= dir_d;
      cnt_ld_q  <= moved_d;
      cnt_par_q <= moved_d ? dir_q + 2'd3 : 2'd0;
    end
  end

  assign bus.cnt_ld  = cnt_ld_q;
  assign bus.cnt_par = cnt_par_q;
`else
  assign bus.cnt_ld  = 1'b0;
  assign bus.cnt_par = 2'd0;
`endif

  assign bus.cnt_en   = cnt_en_q;
  assign bus.cnt_clr  = cnt_clr_q;
  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_addr = {cand_y_q, cand_x_q};
  assign pos_x        = pos_x_q;
  assign pos_y        = pos_y_q;
  assign busy         = busy_q;
  assign moved        = moved_q;
  assign dead_end     = dead_q;
  assign goal         = goal_q;

endmodule

// File: tb/tb_maze_step_unit.sv
// Scoreboard bench for maze_step_unit with behavioural direction counter and wall memory.
module tb_maze_step_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] pos_x, pos_y;
  logic       busy, moved, dead_end, goal;

  maze_step_unit_if #(.COORD_W(4)) bus ();

  maze_step_unit #(.COORD_W(4), .GOAL_X(15), .GOAL_Y(15)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus.master),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .busy     (busy),
    .moved    (moved),
    .dead_end (dead_end),
    .goal     (goal)
  );

  always #5 clk = ~clk;

  typedef struct {int kind; int a; int b; int c;} evt_t;
  // kinds: 0 cnt_en (a=dir), 1 read request (a=addr), 2 moved (x,y,{clr,ld,par}), 3 dead end
  evt_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   walls [256];
  int   mem_delay = 0;
  int   wait_cnt = 0;
  int   cnt_m = 0;
  bit   wrap_m = 1'b0;

  function automatic int mv_code(input int d);
`ifdef MAZE_LAST_DIR_EN
    return 4 + ((d + 3) % 4);
`else
    return 8;
`endif
  endfunction

  task automatic push(input int kind, input int a, input int b, input int c);
    evt_t e;
    e.kind = kind; e.a = a; e.b = b; e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic pop_check(input int kind, input int a, input int b, input int c);
    evt_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_event: got kind=%0d a=%0d b=%0d c=%0d, want none", kind, a, b, c);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.a != a || e.b != b || e.c != c) begin
        miscompares++;
        $display("FAIL event: got kind=%0d a=%0d b=%0d c=%0d, want kind=%0d a=%0d b=%0d c=%0d",
                 kind, a, b, c, e.kind, e.a, e.b, e.c);
      end
    end
  endtask

  // Direction counter model: 2-bit count with sticky carry-out.
  initial begin : counter_model
    logic en, clr, ld;
    logic [1:0] par;
    bus.dir = 2'd0;
    bus.dir_wrap = 1'b0;
    forever begin
      @(negedge clk);
      en = bus.cnt_en; clr = bus.cnt_clr; ld = bus.cnt_ld; par = bus.cnt_par;
      @(posedge clk);
      #1;
      if (clr) begin
        cnt_m = 0; wrap_m = 1'b0;
      end else if (ld) begin
        cnt_m = int'(par);
      end else if (en) begin
        if (cnt_m == 3) wrap_m = 1'b1;
        cnt_m = (cnt_m + 1) % 4;
      end
      bus.dir = 2'(cnt_m);
      bus.dir_wrap = wrap_m;
    end
  end

  // Wall memory: ack after mem_delay extra request cycles, one-cycle ack.
  initial begin : memory_model
    bus.mem_ack = 1'b0;
    bus.mem_wall = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0; bus.mem_wall = 1'b0; wait_cnt = 0;
      end else if (bus.mem_rd) begin
        if (wait_cnt == mem_delay) begin
          bus.mem_ack = 1'b1; bus.mem_wall = walls[int'(bus.mem_addr)];
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: every DUT event is matched against the head of the expectation queue.
  logic       rd_prev = 1'b0;
  logic [7:0] rd_addr = 8'd0;
  always @(negedge clk) begin
    if (!rst) begin
      rd_prev = 1'b0;
    end else begin
      if (bus.cnt_en) pop_check(0, int'(bus.dir), 0, 0);
      if (bus.mem_rd && !rd_prev) begin
        pop_check(1, int'(bus.mem_addr), 0, 0);
        rd_addr = bus.mem_addr;
      end else if (bus.mem_rd) begin
        chk("mem_addr_stable", int'(bus.mem_addr), int'(rd_addr));
      end
      if (moved) pop_check(2, int'(pos_x), int'(pos_y),
                           int'({bus.cnt_clr, bus.cnt_ld, bus.cnt_par}));
      if (dead_end) pop_check(3, int'(pos_x), int'(pos_y), int'(bus.cnt_clr));
      rd_prev = bus.mem_rd;
    end
  end

  task automatic run_step(input int d);
    int n;
    @(negedge clk);
    cnt_m = d; wrap_m = 1'b0; bus.dir = 2'(d); bus.dir_wrap = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && !goal && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("step_timeout", n, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin : stimulus
    int n;
    int rd_seen;
    foreach (walls[i]) walls[i] = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pos_x", int'(pos_x), 0);
    chk("rst_pos_y", int'(pos_y), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_goal", int'(goal), 0);
    chk("rst_mem_rd", int'(bus.mem_rd), 0);
    chk("rst_cnt_en", int'(bus.cnt_en), 0);
    rst = 1'b1;

    // Reset asserted mid-request drops mem_rd and busy immediately.
    mem_delay = 20;
    push(1, 8'h01, 0, 0);
    @(negedge clk);
    cnt_m = 1; bus.dir = 2'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!bus.mem_rd && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_before_reset", int'(bus.mem_rd), 1);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_mem_rd", int'(bus.mem_rd), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_pos", int'({pos_y, pos_x}), 0);
    @(negedge clk);
    rst = 1'b1;
    cnt_m = 0; wrap_m = 1'b0; bus.dir = 2'd0; bus.dir_wrap = 1'b0;
    mem_delay = 0;

    // (0,0) up is off-grid: counter advances, then right is free.
    push(0, 0, 0, 0);
    push(1, 8'h01, 0, 0);
    push(2, 1, 0, mv_code(1));
    run_step(0);
    chk("idle_after_move", int'(busy), 0);

    // Right with ack on the second request cycle.
    mem_delay = 1;
    push(1, 8'h02, 0, 0);
    push(2, 2, 0, mv_code(1));
    run_step(1);
    mem_delay = 0;

`ifdef MAZE_LAST_DIR_EN
    // Wall-follower reload: move down from (2,0) loads dir 1, no clear.
    push(1, 8'h12, 0, 0);
    push(2, 2, 1, mv_code(2));
    run_step(2);
    push(1, 8'h02, 0, 0);
    push(2, 2, 0, mv_code(0));
    run_step(0);
`endif

    // Dead end at (2,0): up off-grid, right/down/left walled.
    walls[8'h03] = 1'b1;
    walls[8'h12] = 1'b1;
    walls[8'h01] = 1'b1;
    push(0, 0, 0, 0);
    push(1, 8'h03, 0, 0);
    push(0, 1, 0, 0);
    push(1, 8'h12, 0, 0);
    push(0, 2, 0, 0);
    push(1, 8'h01, 0, 0);
    push(0, 3, 0, 0);
    push(3, 2, 0, 1);
    run_step(0);
    chk("dead_end_pos", int'({pos_y, pos_x}), 8'h02);
    foreach (walls[i]) walls[i] = 1'b0;

    // Walk down column 2, then along the bottom row to (14,15).
    for (int y = 0; y < 15; y++) begin
      push(1, (y + 1) * 16 + 2, 0, 0);
      push(2, 2, y + 1, mv_code(2));
      run_step(2);
    end
    for (int x = 2; x < 14; x++) begin
      push(1, 15 * 16 + x + 1, 0, 0);
      push(2, x + 1, 15, mv_code(1));
      run_step(1);
    end
    chk("walk_pos", int'({pos_y, pos_x}), 8'hFE);

    // Down at bottom edge is off-grid; counter moves on to left.
    push(0, 2, 0, 0);
    push(1, 8'hFD, 0, 0);
    push(2, 13, 15, mv_code(3));
    run_step(2);
    push(1, 8'hFE, 0, 0);
    push(2, 14, 15, mv_code(1));
    run_step(1);
    chk("goal_before", int'(goal), 0);

    // Final step onto the goal cell.
    push(1, 8'hFF, 0, 0);
    push(2, 15, 15, mv_code(1));
    run_step(1);
    chk("goal_level", int'(goal), 1);
    chk("goal_busy", int'(busy), 1);
    chk("goal_pos", int'({pos_y, pos_x}), 8'hFF);

    // Start is ignored once the goal is reached.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rd_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.mem_rd) rd_seen++;
    end
    chk("no_rd_after_goal", rd_seen, 0);
    chk("goal_held", int'(goal), 1);
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/maze_step_unit.md
Name: maze_step_unit

Overview:
- Consumes the 2-bit direction counter's count and carry-out in the Rat & Maze datapath, and drives that counter's enable, load and clear inputs.
- Holds the rat's current (x,y) position and computes the candidate cell for the current direction.
- Checks the candidate against the maze bounds and the maze wall memory, then either moves the rat, advances the direction, or reports a dead end.
- One step attempt per start pulse; the top-level controller sequences start pulses.

Parameters:
COORD_W, 4, width of each coordinate; maze is 2^COORD_W x 2^COORD_W
GOAL_X, 15, x coordinate of the goal cell
GOAL_Y, 15, y coordinate of the goal cell

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  begin one step attempt; sampled only in IDLE
dir  in  2  current direction from the direction counter; 0=up(y-1), 1=right(x+1), 2=down(y+1), 3=left(x-1)
dir_wrap  in  1  direction counter carry-out; 1 = all four directions exhausted
cnt_en  out  1  increment the direction counter
cnt_ld  out  1  load the direction counter from cnt_par
cnt_par  out  2  load value for the direction counter
cnt_clr  out  1  synchronous clear of the direction counter (count and carry)
mem_rd  out  1  wall memory read request
mem_addr  out  2*COORD_W  {cand_y, cand_x}
mem_ack  in  1  read data valid
mem_wall  in  1  1 = candidate cell is a wall; valid with mem_ack
pos_x  out  COORD_W  current x position
pos_y  out  COORD_W  current y position
busy  out  1  1 when not in IDLE
moved  out  1  one-cycle pulse: position updated
dead_end  out  1  one-cycle pulse: no direction possible from this cell
goal  out  1  level; set when position equals (GOAL_X, GOAL_Y)

Behaviour:
- Reset (rst=0, async):
  - FSM to IDLE.
  - pos_x = pos_y = 0.
  - All other outputs 0, including mem_rd (deasserts immediately, even mid-request).
- States:
  - IDLE: busy=0. start=1 -> CHECK. start is ignored while busy.
  - CHECK (1 cycle): compute cand from pos and dir.
    - up with y=0, left with x=0, right with x=max, or down with y=max -> NEXT. No wrap-around moves.
    - Otherwise -> REQ.
  - REQ: mem_rd=1 and mem_addr held stable until mem_ack=1.
    - On the mem_ack cycle: mem_wall=1 -> NEXT; mem_wall=0 -> MOVE.
    - mem_ack outside REQ is ignored.
  - MOVE (1 cycle):
    - pos <= cand; moved=1; cnt_clr=1.
    - Next state: -> DONE if cand == goal cell, else -> IDLE.
  - NEXT (1 cycle): cnt_en=1 -> SETTLE.
  - SETTLE (1 cycle): samples the updated dir/dir_wrap.
    - dir_wrap=1: dead_end=1, cnt_clr=1 -> IDLE.
    - Otherwise -> CHECK.
  - DONE: goal=1, busy=1. Held until reset; start is ignored.
- cnt_ld and cnt_par are driven 0 in all states. They are reserved for the optional feature.
- Latency:
  - Free move: start to moved = 3 cycles + memory wait.
  - Blocked direction retry: 2 extra cycles before the next CHECK.
- Outputs are registered except mem_addr, which is driven from the registered cand.

Optional Feature:
MAZE_LAST_DIR_EN:
- Defined: MOVE asserts cnt_ld=1 with cnt_par=(dir+3) mod 4, and does not assert cnt_clr. The search from the new cell therefore starts one direction counter-clockwise of the move (wall-follower).
- Undefined: MOVE asserts cnt_clr; cnt_ld and cnt_par are tied 0.

Test Plan:
- Reset while in REQ with mem_rd=1 -> mem_rd=0 and busy=0 immediately; pos=(0,0).
- pos=(0,0), dir=1, start, mem_ack on 2nd REQ cycle with mem_wall=0 -> moved pulse, pos=(1,0), cnt_clr pulse, back to IDLE.
- pos=(0,0), dir=0 -> no mem_rd; cnt_en pulse; with dir=1 after SETTLE, re-enters CHECK.
- Every direction walled (counter model wraps, dir_wrap=1 after 4th cnt_en) -> dead_end pulse, cnt_clr, pos unchanged.
- pos=(14,15), dir=1, free -> moved, pos=(15,15), goal=1; later start pulses produce no mem_rd.
- MAZE_LAST_DIR_EN defined, move with dir=2 -> cnt_ld=1, cnt_par=1, cnt_clr=0.
